// File: rtl/cpc_hid_pkg.sv
// Shared definitions for the CPC HID input path: delta width, direction bit
// indices and the saturating residual adder used by the mouse axis accumulators.
package cpc_hid_pkg;

   localparam int DELTA_W = 9;
   localparam int DIR_POS = 0;
   localparam int DIR_NEG = 1;

   // Adds a sign-extended delta to a residual and clamps to +/-(2^(acc_w-1)-1).
   function automatic logic signed [31:0] sat_add(
      input logic signed [31:0]        residual,
      input logic signed [DELTA_W-1:0] delta,
      input int                        acc_w
   );
      logic signed [32:0] sum;
      logic signed [32:0] hi;
      sum = {residual[31], residual} + {{(33-DELTA_W){delta[DELTA_W-1]}}, delta};
      hi  = (33'sd1 <<< (acc_w - 1)) - 33'sd1;
      if (sum > hi) begin
         return hi[31:0];
      end else if (sum < -hi) begin
         return (-hi);
      end else begin
         return sum[31:0];
      end
   endfunction

endpackage

// File: rtl/mouse_axis_acc.sv
// One mouse axis: saturating signed residual, direction-pulse pair and busy flag.
// Define MOUSE_ACCEL_EN to double the per-pulse step while |residual| > ACCEL_THR.
module mouse_axis_acc
   import cpc_hid_pkg::*;
#(
   parameter int ACC_W     = 10,
   parameter int STEP      = 2,
   parameter int ACCEL_THR = 64
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               set,
   input  logic [DELTA_W-1:0] delta,
   input  logic               rel,
   output logic [1:0]         dir,
   output logic               busy
);

   if (ACC_W < 10 || ACC_W > 32 || STEP < 1 || STEP > (1 << (ACC_W - 2)) || ACCEL_THR < 0) begin : g_bad_param
      $error("mouse_axis_acc: parameter out of range");
   end

   logic signed [ACC_W-1:0] res_r;
   logic signed [ACC_W-1:0] res_c;
   logic signed [ACC_W-1:0] res_n;
   logic [ACC_W-1:0]        mag_s;
   logic [ACC_W-1:0]        step_s;
   logic [ACC_W-1:0]        take_s;
   logic [1:0]              dir_r;
   logic [1:0]              dir_n;
   logic                    busy_r;

   // Release, then consume one step into a pulse, then accumulate the new delta.
   always_comb begin
      mag_s = res_r[ACC_W-1] ? $unsigned(-res_r) : $unsigned(res_r);
`ifdef MOUSE_ACCEL_EN
      step_s = (mag_s > ACC_W'(ACCEL_THR)) ? ACC_W'(2 * STEP) : ACC_W'(STEP);
`else
      step_s = ACC_W'(STEP);
`endif
      take_s = (mag_s < step_s) ? mag_s : step_s;
      res_c  = res_r;
      dir_n  = dir_r;
      if (rel) begin
         dir_n = 2'b00;
      end else if (dir_r == 2'b00 && res_r != '0) begin
         if (res_r[ACC_W-1]) begin
            dir_n[DIR_NEG] = 1'b1;
            res_c          = res_r + $signed(take_s);
         end else begin
            dir_n[DIR_POS] = 1'b1;
            res_c          = res_r - $signed(take_s);
         end
      end else begin
         dir_n = dir_r;
      end
      if (set) begin
         res_n = ACC_W'(sat_add(32'(res_c), delta, ACC_W));
      end else begin
         res_n = res_c;
      end
   end

   // Residual, pulse pair and busy flag registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         res_r  <= '0;
         dir_r  <= 2'b00;
         busy_r <= 1'b0;
      end else begin
         res_r  <= res_n;
         dir_r  <= dir_n;
         busy_r <= (res_n != '0);
      end
   end

   assign dir  = dir_r;
   assign busy = busy_r;

endmodule

// File: rtl/mouse_pulse_gen.sv
// Multi-axis PS/2 mouse delta to CPC direction-pulse converter: sel falling-edge
// detector plus per-axis accumulators. Optional feature macro: MOUSE_ACCEL_EN.
module mouse_pulse_gen
   import cpc_hid_pkg::*;
#(
   parameter int AXES      = 2,
   parameter int ACC_W     = 10,
   parameter int STEP      = 2,
   parameter int ACCEL_THR = 64
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    set,
   input  logic [DELTA_W*AXES-1:0] offset,
   input  logic                    sel,
   output logic [2*AXES-1:0]       dir,
   output logic [AXES-1:0]         busy
);

   if (AXES < 1 || AXES > 4) begin : g_bad_axes
      $error("mouse_pulse_gen: AXES out of range");
   end

   logic sel_q;
   logic rel_s;

   // History of sel so the end of a mouse-row scan can be detected.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sel_q <= 1'b0;
      end else begin
         sel_q <= sel;
      end
   end

   assign rel_s = sel_q & ~sel;

   for (genvar i = 0; i < AXES; i++) begin : g_axis
      mouse_axis_acc #(
         .ACC_W     (ACC_W),
         .STEP      (STEP),
         .ACCEL_THR (ACCEL_THR)
      ) u_axis (
         .clk     (clk),
         .reset_n (reset_n),
         .set     (set),
         .delta   (offset[DELTA_W*i +: DELTA_W]),
         .rel     (rel_s),
         .dir     (dir[2*i +: 2]),
         .busy    (busy[i])
      );
   end

endmodule

// File: tb/tb_mouse_pulse_gen.sv
// Directed self-checking bench for mouse_pulse_gen (AXES=2, ACC_W=10, STEP=2).
module tb_mouse_pulse_gen;

   logic        clk;
   logic        reset_n;
   logic        set;
   logic [17:0] offset;
   logic        sel;
   logic [3:0]  dir;
   logic [1:0]  busy;

   int n_cmp;
   int n_err;

   mouse_pulse_gen #(
      .AXES      (2),
      .ACC_W     (10),
      .STEP      (2),
      .ACCEL_THR (64)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .set     (set),
      .offset  (offset),
      .sel     (sel),
      .dir     (dir),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_set(input logic [8:0] d0, input logic [8:0] d1);
      set    = 1'b1;
      offset = {d1, d0};
      tick();
      set    = 1'b0;
      offset = 18'd0;
   endtask

   // One mouse-row scan; afterwards dir shows the next pulse, if any.
   task automatic scan();
      sel = 1'b1;
      tick();
      sel = 1'b0;
      tick();
      tick();
   endtask

   task automatic count_pulses(input int ax, output int pos, output int neg);
      pos = 0;
      neg = 0;
      for (int i = 0; i < 400; i++) begin
         if (dir[2*ax +: 2] == 2'b00) break;
         if (dir[2*ax]) pos++;
         if (dir[2*ax+1]) neg++;
         scan();
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      set     = 1'b0;
      sel     = 1'b0;
      offset  = 18'd0;
      tick();
      tick();
      n_cmp++;
      if (dir !== 4'b0000) begin n_err++; $display("FAIL reset_dir: got %b expected %b", dir, 4'b0000); end
      n_cmp++;
      if (busy !== 2'b00) begin n_err++; $display("FAIL reset_busy: got %b expected %b", busy, 2'b00); end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int p;
      int n;
      do_set(9'd5, 9'd0);
      tick();
      n_cmp++;
      if (dir !== 4'b0001) begin n_err++; $display("FAIL basic_first_dir: got %b expected %b", dir, 4'b0001); end
      n_cmp++;
      if (busy !== 2'b01) begin n_err++; $display("FAIL basic_busy: got %b expected %b", busy, 2'b01); end
      count_pulses(0, p, n);
      n_cmp++;
      if (p !== 3) begin n_err++; $display("FAIL basic_pos_count: got %0d expected %0d", p, 3); end
      n_cmp++;
      if (n !== 0) begin n_err++; $display("FAIL basic_neg_count: got %0d expected %0d", n, 0); end
      n_cmp++;
      if (busy !== 2'b00) begin n_err++; $display("FAIL basic_busy_end: got %b expected %b", busy, 2'b00); end
      scan();
      n_cmp++;
      if (dir !== 4'b0000) begin n_err++; $display("FAIL basic_no_4th: got %b expected %b", dir, 4'b0000); end
   endtask

   task automatic test_negative_accumulate();
      int p;
      int n;
      set    = 1'b1;
      offset = {9'd0, 9'h1FD};
      tick();
      offset = {9'd0, 9'h1FC};
      tick();
      set    = 1'b0;
      offset = 18'd0;
      n_cmp++;
      if (dir !== 4'b0010) begin n_err++; $display("FAIL neg_first_dir: got %b expected %b", dir, 4'b0010); end
      count_pulses(0, p, n);
      n_cmp++;
      if (n !== 4) begin n_err++; $display("FAIL neg_count: got %0d expected %0d", n, 4); end
      n_cmp++;
      if (p !== 0) begin n_err++; $display("FAIL neg_pos_count: got %0d expected %0d", p, 0); end
      n_cmp++;
      if (busy !== 2'b00) begin n_err++; $display("FAIL neg_busy_end: got %b expected %b", busy, 2'b00); end
   endtask

   task automatic test_two_axes();
      do_set(9'd1, 9'h1FE);
      tick();
      n_cmp++;
      if (dir !== 4'b1001) begin n_err++; $display("FAIL axes_dir: got %b expected %b", dir, 4'b1001); end
      n_cmp++;
      if (busy !== 2'b00) begin n_err++; $display("FAIL axes_busy: got %b expected %b", busy, 2'b00); end
      scan();
      n_cmp++;
      if (dir !== 4'b0000) begin n_err++; $display("FAIL axes_released: got %b expected %b", dir, 4'b0000); end
   endtask

   task automatic test_simultaneous();
      do_set(9'd2, 9'd0);
      tick();
      n_cmp++;
      if (dir !== 4'b0001) begin n_err++; $display("FAIL simul_setup_dir: got %b expected %b", dir, 4'b0001); end
      sel = 1'b1;
      tick();
      sel    = 1'b0;
      set    = 1'b1;
      offset = {9'd0, 9'd2};
      tick();
      set    = 1'b0;
      offset = 18'd0;
      n_cmp++;
      if (dir !== 4'b0000) begin n_err++; $display("FAIL simul_release_dir: got %b expected %b", dir, 4'b0000); end
      n_cmp++;
      if (busy !== 2'b01) begin n_err++; $display("FAIL simul_busy: got %b expected %b", busy, 2'b01); end
      tick();
      n_cmp++;
      if (dir !== 4'b0001) begin n_err++; $display("FAIL simul_next_pulse: got %b expected %b", dir, 4'b0001); end
      scan();
      n_cmp++;
      if (dir !== 4'b0000 || busy !== 2'b00) begin
         n_err++; $display("FAIL simul_idle: got dir %b busy %b expected 0000 00", dir, busy);
      end
   endtask

   task automatic test_saturation();
      int p;
      int n;
      set    = 1'b1;
      offset = {9'd0, 9'd255};
      tick();
      tick();
      tick();
      set    = 1'b0;
      offset = 18'd0;
      n_cmp++;
      if (dir !== 4'b0001) begin n_err++; $display("FAIL sat_dir: got %b expected %b", dir, 4'b0001); end
      count_pulses(0, p, n);
      n_cmp++;
      if (p !== 257) begin n_err++; $display("FAIL sat_pos_count: got %0d expected %0d", p, 257); end
      n_cmp++;
      if (n !== 0) begin n_err++; $display("FAIL sat_neg_count: got %0d expected %0d", n, 0); end
   endtask

   task automatic test_accel();
      int p;
      int n;
      int exp_p;
`ifdef MOUSE_ACCEL_EN
      exp_p = 41;
`else
      exp_p = 50;
`endif
      do_set(9'd100, 9'd0);
      tick();
      count_pulses(0, p, n);
      n_cmp++;
      if (p !== exp_p) begin n_err++; $display("FAIL accel_count: got %0d expected %0d", p, exp_p); end
      n_cmp++;
      if (busy !== 2'b00) begin n_err++; $display("FAIL accel_busy_end: got %b expected %b", busy, 2'b00); end
   endtask

   task automatic test_async_reset();
      do_set(9'd37, 9'd0);
      tick();
      n_cmp++;
      if (dir !== 4'b0001) begin n_err++; $display("FAIL areset_pre_dir: got %b expected %b", dir, 4'b0001); end
      #2;
      reset_n = 1'b0;
      #1;
      n_cmp++;
      if (dir !== 4'b0000) begin n_err++; $display("FAIL areset_dir: got %b expected %b", dir, 4'b0000); end
      n_cmp++;
      if (busy !== 2'b00) begin n_err++; $display("FAIL areset_busy: got %b expected %b", busy, 2'b00); end
      #2;
      reset_n = 1'b1;
      tick();
      scan();
      n_cmp++;
      if (dir !== 4'b0000 || busy !== 2'b00) begin
         n_err++; $display("FAIL areset_after: got dir %b busy %b expected 0000 00", dir, busy);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_basic();
      test_negative_accumulate();
      test_two_axes();
      test_simultaneous();
      test_saturation();
      test_accel();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
